// File: rtl/decode_pkg.sv
// Shared definitions for the DLPRV32 decode stage: RV32I major opcodes,
// format-class encodings, FSM state encoding and small decode helpers.
package decode_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    TYPE_R   = 3'd0,
    TYPE_I   = 3'd1,
    TYPE_S   = 3'd2,
    TYPE_B   = 3'd3,
    TYPE_U   = 3'd4,
    TYPE_J   = 3'd5,
    TYPE_ILL = 3'd7
  } instr_type_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_VALID  = 2'd2
  } state_e;

  // Map a 7-bit opcode to its format class; anything unrecognised,
  // including a compressed-style low pair, is ILL.
  function automatic instr_type_e classify(input logic [6:0] op);
    instr_type_e t;
    if (op[1:0] != 2'b11) begin
      t = TYPE_ILL;
    end else begin
      case (op)
        OP_R:                             t = TYPE_R;
        OP_IMM, OP_LOAD, OP_JALR, OP_SYS: t = TYPE_I;
        OP_STORE:                         t = TYPE_S;
        OP_BRANCH:                        t = TYPE_B;
        OP_LUI, OP_AUIPC:                 t = TYPE_U;
        OP_JAL:                           t = TYPE_J;
        default:                          t = TYPE_ILL;
      endcase
    end
    return t;
  endfunction

  // Formats that write a destination register.
  function automatic logic writes_rd(input instr_type_e t);
    logic w;
    case (t)
      TYPE_R, TYPE_I, TYPE_U, TYPE_J: w = 1'b1;
      default:                        w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/decode_imm_gen.sv
// Combinational immediate generator: builds the sign-extended immediate
// for the given format class. R and ILL produce zero.
module imm_gen
  import decode_pkg::*;
(
  input  logic [31:0]  instr,
  input  instr_type_e  instr_type,
  output logic [31:0]  imm
);

  // The opcode bits play no part in immediate assembly.
  logic w_unused_op;
  assign w_unused_op = ^instr[6:0];

  // Select and sign-extend the immediate bits for the format.
  always_comb begin
    imm = 32'd0;
    case (instr_type)
      TYPE_I:  imm = {{20{instr[31]}}, instr[31:20]};
      TYPE_S:  imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      TYPE_B:  imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      TYPE_U:  imm = {instr[31:12], 12'd0};
      TYPE_J:  imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
  end

endmodule

// File: rtl/decode.sv
// DLPRV32 RV32I decode stage. Accepts one instruction per handshake in
// IDLE, decodes it from the captured copy in DECODE, and holds the
// registered bundle in VALID until execute consumes it.
// Build option: DECODE_ILLEGAL_EN enables illegal-encoding detection,
// the illegal flag and the saturating ill_count.
module decode
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cs_decode,
  input  logic [31:0] instr,
  output logic        rdy_decode,
  output logic        cs_D_to_E,
  input  logic        rdy_exec,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] imm,
  output logic [2:0]  instr_type,
  output logic        rd_valid,
  output logic        illegal,
  output logic [7:0]  ill_count
);

  state_e      r_state;
  state_e      w_next_state;
  logic [31:0] r_instr_q;

  logic [6:0]  r_opcode;
  logic [4:0]  r_rd, r_rs1, r_rs2;
  logic [2:0]  r_funct3;
  logic [6:0]  r_funct7;
  logic [31:0] r_imm;
  instr_type_e r_type;
  logic        r_rd_valid;
  logic        r_illegal;

  instr_type_e w_class;
  instr_type_e w_type;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic        w_rd_valid;
  logic        w_illegal;
  logic [31:0] w_imm;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: IDLE -> DECODE on accept, DECODE -> VALID, VALID -> IDLE on consume.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (cs_decode) begin
          w_next_state = ST_DECODE;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_DECODE: w_next_state = ST_VALID;
      ST_VALID: begin
        if (rdy_exec) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_VALID;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign rdy_decode = (r_state == ST_IDLE);
  assign cs_D_to_E  = (r_state == ST_VALID);

  // Capture the instruction word only on the accept cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr_q <= 32'd0;
    end else if ((r_state == ST_IDLE) && cs_decode) begin
      r_instr_q <= instr;
    end
  end

  assign w_class = classify(r_instr_q[6:0]);

  // Resolve format class, register indices and writeback flag, applying
  // the illegal-encoding policy of the current build.
  always_comb begin
    w_type     = w_class;
    w_rd       = r_instr_q[11:7];
    w_rs1      = r_instr_q[19:15];
    w_rs2      = r_instr_q[24:20];
    w_illegal  = 1'b0;
    w_rd_valid = writes_rd(w_class);
`ifdef DECODE_ILLEGAL_EN
    if (w_class == TYPE_ILL) begin
      w_illegal  = 1'b1;
      w_rd       = 5'd0;
      w_rs1      = 5'd0;
      w_rs2      = 5'd0;
      w_rd_valid = 1'b0;
    end else begin
      w_illegal  = 1'b0;
    end
`else
    if (w_class == TYPE_ILL) begin
      w_type     = TYPE_R;
      w_rd_valid = 1'b1;
    end else begin
      w_type     = w_class;
    end
`endif
  end

  imm_gen u_imm_gen (
    .instr      (r_instr_q),
    .instr_type (w_type),
    .imm        (w_imm)
  );

  // Register the decoded bundle in DECODE; it then holds through VALID and IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_opcode   <= 7'd0;
      r_rd       <= 5'd0;
      r_rs1      <= 5'd0;
      r_rs2      <= 5'd0;
      r_funct3   <= 3'd0;
      r_funct7   <= 7'd0;
      r_imm      <= 32'd0;
      r_type     <= TYPE_R;
      r_rd_valid <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (r_state == ST_DECODE) begin
      r_opcode   <= r_instr_q[6:0];
      r_rd       <= w_rd;
      r_rs1      <= w_rs1;
      r_rs2      <= w_rs2;
      r_funct3   <= r_instr_q[14:12];
      r_funct7   <= r_instr_q[31:25];
      r_imm      <= w_imm;
      r_type     <= w_type;
      r_rd_valid <= w_rd_valid;
      r_illegal  <= w_illegal;
    end
  end

`ifdef DECODE_ILLEGAL_EN
  logic [7:0] r_ill_count;

  // Count illegal words as they enter VALID, saturating at 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ill_count <= 8'd0;
    end else if ((r_state == ST_DECODE) && w_illegal && (r_ill_count != 8'hFF)) begin
      r_ill_count <= r_ill_count + 8'd1;
    end
  end

  assign ill_count = r_ill_count;
`else
  assign ill_count = 8'd0;
`endif

  assign opcode     = r_opcode;
  assign rd         = r_rd;
  assign rs1        = r_rs1;
  assign rs2        = r_rs2;
  assign funct3     = r_funct3;
  assign funct7     = r_funct7;
  assign imm        = r_imm;
  assign instr_type = r_type;
  assign rd_valid   = r_rd_valid;
  assign illegal    = r_illegal;

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for the decode stage: the stimulus process pushes the
// hand-computed bundle for each accepted word; a monitor pops and compares
// whenever execute consumes a bundle.
module tb_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs_decode;
  logic [31:0] instr;
  logic        rdy_decode;
  logic        cs_D_to_E;
  logic        rdy_exec;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic [2:0]  instr_type;
  logic        rd_valid;
  logic        illegal;
  logic [7:0]  ill_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [2:0]  itype;
    logic        rdv;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  decode dut (
    .clk        (clk),
    .rst        (rst),
    .cs_decode  (cs_decode),
    .instr      (instr),
    .rdy_decode (rdy_decode),
    .cs_D_to_E  (cs_D_to_E),
    .rdy_exec   (rdy_exec),
    .opcode     (opcode),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .funct3     (funct3),
    .funct7     (funct7),
    .imm        (imm),
    .instr_type (instr_type),
    .rd_valid   (rd_valid),
    .illegal    (illegal),
    .ill_count  (ill_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [6:0] op, input logic [4:0] e_rd,
                              input logic [4:0] e_rs1, input logic [4:0] e_rs2,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] e_imm, input logic [2:0] t,
                              input logic v, input logic il);
    exp_t e;
    e.opcode = op; e.rd = e_rd; e.rs1 = e_rs1; e.rs2 = e_rs2;
    e.funct3 = f3; e.funct7 = f7; e.imm = e_imm; e.itype = t;
    e.rdv = v; e.ill = il;
    return e;
  endfunction

  // Monitor: compare the presented bundle against the scoreboard on consume.
  always @(negedge clk) begin
    if (!rst && cs_D_to_E && rdy_exec) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow actual=bundle required=none at %0t", $time);
      end else begin
        mon_e = sb_q.pop_front();
        chk("opcode",     {25'd0, opcode},     {25'd0, mon_e.opcode});
        chk("rd",         {27'd0, rd},         {27'd0, mon_e.rd});
        chk("rs1",        {27'd0, rs1},        {27'd0, mon_e.rs1});
        chk("rs2",        {27'd0, rs2},        {27'd0, mon_e.rs2});
        chk("funct3",     {29'd0, funct3},     {29'd0, mon_e.funct3});
        chk("funct7",     {25'd0, funct7},     {25'd0, mon_e.funct7});
        chk("imm",        imm,                 mon_e.imm);
        chk("instr_type", {29'd0, instr_type}, {29'd0, mon_e.itype});
        chk("rd_valid",   {31'd0, rd_valid},   {31'd0, mon_e.rdv});
        chk("illegal",    {31'd0, illegal},    {31'd0, mon_e.ill});
      end
    end
  end

  // Present a word, wait (bounded) for accept, push its expectation, check latency.
  task automatic send(input logic [31:0] w, input exp_t e);
    bit accepted;
    accepted = 1'b0;
    cs_decode = 1'b1;
    instr = w;
    for (int k = 0; k < 20; k++) begin
      if (rdy_decode) begin
        @(posedge clk);
        accepted = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    #1;
    cs_decode = 1'b0;
    if (!accepted) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      sb_q.push_back(e);
      chk("decode_not_valid_yet", {31'd0, cs_D_to_E}, 32'd0);
      @(posedge clk);
      #1;
      chk("latency_valid", {31'd0, cs_D_to_E}, 32'd1);
    end
  endtask

  // Wait (bounded) for the consume edge, then require IDLE on the next cycle.
  task automatic wait_consume();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (cs_D_to_E && rdy_exec) begin
        @(posedge clk);
        #1;
        done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      chk("consume_timeout", 32'd0, 32'd1);
    end else begin
      chk("idle_after_consume", {30'd0, rdy_decode, cs_D_to_E}, 32'd2);
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    cs_decode = 1'b0;
    instr = 32'd0;
    rdy_exec = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_rdy_decode", {31'd0, rdy_decode}, 32'd1);
    chk("rst_cs_D_to_E",  {31'd0, cs_D_to_E},  32'd0);
    chk("rst_imm",        imm,                 32'd0);
    chk("rst_ill_count",  {24'd0, ill_count},  32'd0);

    // addi x1,x0,5
    send(32'h00500093, mk(7'h13, 5'd1, 5'd0, 5'd5, 3'd0, 7'h00, 32'd5, 3'd1, 1'b1, 1'b0));
    wait_consume();

    // sw x2,-4(x1)
    send(32'hFE20AE23, mk(7'h23, 5'd28, 5'd1, 5'd2, 3'd2, 7'h7F, 32'hFFFFFFFC, 3'd2, 1'b0, 1'b0));
    wait_consume();

    // beq x1,x2,+8 under backpressure with cs_decode pulsing an illegal word
    rdy_exec = 1'b0;
    send(32'h00208463, mk(7'h63, 5'd8, 5'd1, 5'd2, 3'd0, 7'h00, 32'd8, 3'd3, 1'b0, 1'b0));
    for (int i = 0; i < 5; i++) begin
      cs_decode = ~i[0];
      instr = 32'hFFFFFFFF;
      @(posedge clk);
      #1;
      chk("bp_valid_hold", {31'd0, cs_D_to_E}, 32'd1);
      chk("bp_type_hold",  {29'd0, instr_type}, 32'd3);
      chk("bp_imm_hold",   imm, 32'd8);
      chk("bp_ill_count",  {24'd0, ill_count}, 32'd0);
    end
    cs_decode = 1'b0;
    rdy_exec = 1'b1;
    wait_consume();

    // All-ones word
`ifdef DECODE_ILLEGAL_EN
    send(32'hFFFFFFFF, mk(7'h7F, 5'd0, 5'd0, 5'd0, 3'd7, 7'h7F, 32'd0, 3'd7, 1'b0, 1'b1));
    chk("ill_count_one", {24'd0, ill_count}, 32'd1);
`else
    send(32'hFFFFFFFF, mk(7'h7F, 5'd31, 5'd31, 5'd31, 3'd7, 7'h7F, 32'd0, 3'd0, 1'b1, 1'b0));
    chk("ill_count_tied", {24'd0, ill_count}, 32'd0);
`endif
    wait_consume();

    // lui x5,0x12345
    send(32'h123452B7, mk(7'h37, 5'd5, 5'd8, 5'd3, 3'd5, 7'h09, 32'h12345000, 3'd4, 1'b1, 1'b0));
    wait_consume();

    // Reset while holding a bundle in VALID
    rdy_exec = 1'b0;
    send(32'h00500093, mk(7'h13, 5'd1, 5'd0, 5'd5, 3'd0, 7'h00, 32'd5, 3'd1, 1'b1, 1'b0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    if (sb_q.size() > 0) begin
      void'(sb_q.pop_front());
    end
    chk("mid_rst_cs_D_to_E",  {31'd0, cs_D_to_E},  32'd0);
    chk("mid_rst_rdy_decode", {31'd0, rdy_decode}, 32'd1);
    chk("mid_rst_opcode",     {25'd0, opcode},     32'd0);
    chk("mid_rst_regs",       {17'd0, rd, rs1, rs2}, 32'd0);
    chk("mid_rst_funct",      {22'd0, funct3, funct7}, 32'd0);
    chk("mid_rst_imm",        imm, 32'd0);
    chk("mid_rst_type",       {29'd0, instr_type}, 32'd0);
    chk("mid_rst_flags",      {30'd0, rd_valid, illegal}, 32'd0);
    chk("mid_rst_ill_count",  {24'd0, ill_count}, 32'd0);
    rdy_exec = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
